// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and memory access.
// Serialises data-then-fetch and drives the pipeline-wide busywait stall.
module mem_port_arbiter #(
   parameter logic [3:0] FETCH_READ_CODE = 4'b1010
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_inst,
   input  logic [31:0] ma_addr,
   input  logic [31:0] ma_wdata,
   input  logic [3:0]  ma_read,
   input  logic [2:0]  ma_write,
   output logic [31:0] ma_rdata,
   output logic        busywait,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_read,
   output logic [2:0]  mem_write,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int unsigned RD_W = 4;
   localparam int unsigned WR_W = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DATA  = 3'd1,
      GAP   = 3'd2,
      FETCH = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t state;
   logic   ma_pending_c;

   assign ma_pending_c = (ma_read != RD_W'(0)) || (ma_write != WR_W'(0));

   // Stall: combinational in IDLE so the requesting step freezes immediately.
   always_comb begin
      busywait = 1'b0;
      if (!rst) begin
         case (state)
            IDLE:    busywait = if_req | ma_pending_c;
            DATA,
            GAP,
            FETCH:   busywait = 1'b1;
            default: busywait = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         if_inst   <= 32'h0;
         ma_rdata  <= 32'h0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_read  <= RD_W'(0);
         mem_write <= WR_W'(0);
      end else begin
         case (state)
            IDLE: begin
               if (ma_pending_c) begin
                  mem_addr  <= ma_addr;
                  mem_wdata <= ma_wdata;
                  mem_write <= ma_write;
                  // A store takes priority; never issue read and write together.
                  mem_read  <= (ma_write != WR_W'(0)) ? RD_W'(0) : ma_read;
                  state     <= DATA;
               end else if (if_req) begin
                  mem_addr  <= if_addr;
                  mem_read  <= FETCH_READ_CODE;
                  mem_write <= WR_W'(0);
                  state     <= FETCH;
               end
            end
            DATA: begin
               if (mem_ack) begin
                  if (mem_read != RD_W'(0)) ma_rdata <= mem_rdata;
                  mem_read  <= RD_W'(0);
                  mem_write <= WR_W'(0);
                  state     <= if_req ? GAP : DONE;
               end
            end
            GAP: begin
               mem_addr <= if_addr;
               mem_read <= FETCH_READ_CODE;
               state    <= FETCH;
            end
            FETCH: begin
               if (mem_ack) begin
                  if_inst  <= mem_rdata;
                  mem_read <= RD_W'(0);
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
